// File: rtl/aha_clock_div_switch_pkg.sv
// aha_clock_div_switch_pkg: shared defaults and parameter sanity helper for the clock divider switch
package aha_clock_div_switch_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_CH_W = 2;
  function automatic logic ch_w_ok(input int num_ch, input int ch_w);
    return (1 << ch_w) >= num_ch;
  endfunction
endpackage

// File: rtl/aha_clock_div_channel.sv
// aha_clock_div_channel: one divider channel producing a clock-enable pulse every div_cur+1 cycles
module aha_clock_div_channel #(
  parameter int CNT_W = 8,
  parameter int RESET_DIV = 0,
  parameter logic RESET_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             apply,
  input  logic [CNT_W-1:0] apply_div,
  input  logic             apply_en,
  output logic             term,
  output logic             clk_en,
  output logic             active
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;
  assign term = active & (cnt == div_cur);
  // count through the period; the old terminal pulse survives an apply, which restarts the phase
  always_ff @(posedge CLK)
    if (!RESETn) begin
      cnt <= '0;
      div_cur <= CNT_W'(RESET_DIV);
      active <= RESET_EN;
      clk_en <= 1'b0;
    end else begin
      clk_en <= term;
      cnt <= (apply | term | ~active) ? '0 : cnt + 1'b1;
      if (apply) begin
        div_cur <= apply_div;
        active <= apply_en;
      end
    end
endmodule

// File: rtl/aha_clock_div_switch.sv
// aha_clock_div_switch: NUM_CH clock-enable generators with boundary-aligned ratio/enable changes
module aha_clock_div_switch
  import aha_clock_div_switch_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int CH_W = DEF_CH_W,
  parameter int RESET_DIV = 0,
  parameter logic [NUM_CH-1:0] RESET_EN = {NUM_CH{1'b1}}
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [CH_W-1:0]   REQ_CH,
  input  logic [CNT_W-1:0]  REQ_DIV,
  input  logic              REQ_EN,
  output logic              ACK_VALID,
  output logic [CH_W-1:0]   ACK_CH,
  output logic              ACK_ERR,
  output logic [NUM_CH-1:0] CLK_EN_OUT,
  output logic [NUM_CH-1:0] CH_ACTIVE
);
  logic              busy;
  logic              pend_en;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_div;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] apply;
  logic              bad;
  logic              done;
  if (!ch_w_ok(NUM_CH, CH_W)) begin : g_ch_w_check
    $error("CH_W too narrow to address NUM_CH channels");
  end
  assign REQ_READY = ~busy;
  assign bad = busy & (int'(pend_ch) >= NUM_CH);
  assign done = bad | (|apply);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply[i] = busy & (pend_ch == CH_W'(i)) & (term[i] | ~CH_ACTIVE[i]);
    aha_clock_div_channel #(
      .CNT_W(CNT_W),
      .RESET_DIV(RESET_DIV),
      .RESET_EN(RESET_EN[i])
    ) u_ch (
      .CLK(CLK),
      .RESETn(RESETn),
      .apply(apply[i]),
      .apply_div(pend_div),
      .apply_en(pend_en),
      .term(term[i]),
      .clk_en(CLK_EN_OUT[i]),
      .active(CH_ACTIVE[i])
    );
  end
  // single pending slot: accept when free, release and acknowledge on apply or bad address
  always_ff @(posedge CLK)
    if (!RESETn) begin
      busy <= 1'b0;
      pend_ch <= '0;
      pend_div <= '0;
      pend_en <= 1'b0;
      ACK_VALID <= 1'b0;
      ACK_ERR <= 1'b0;
      ACK_CH <= '0;
    end else begin
      ACK_VALID <= done;
      ACK_ERR <= bad;
      if (done) ACK_CH <= pend_ch;
      if (done) busy <= 1'b0;
      else if (REQ_VALID & ~busy) begin
        busy <= 1'b1;
        pend_ch <= REQ_CH;
        pend_div <= REQ_DIV;
        pend_en <= REQ_EN;
      end
    end
endmodule

// File: tb/tb_aha_clock_div_switch.sv
// tb_aha_clock_div_switch: directed plus random requests checked against a period-arithmetic model
module tb_aha_clock_div_switch;
  localparam int N = 4;
  localparam int CW = 8;
  localparam int HW = 3;
  localparam int RD = 3;
  logic CLK = 0;
  logic RESETn = 0;
  logic REQ_VALID = 0;
  logic REQ_EN = 0;
  logic [HW-1:0] REQ_CH = '0;
  logic [CW-1:0] REQ_DIV = '0;
  logic REQ_READY, ACK_VALID, ACK_ERR;
  logic [HW-1:0] ACK_CH;
  logic [N-1:0] CLK_EN_OUT, CH_ACTIVE;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit m_busy, m_pen, m_av, m_ae;
  int m_pch, m_pdiv, m_ach;
  bit m_act[N];
  bit m_en[N];
  int m_div[N];
  int m_s[N];
  always #5 CLK = ~CLK;
  aha_clock_div_switch #(.NUM_CH(N), .CNT_W(CW), .CH_W(HW), .RESET_DIV(RD)) dut (
    .CLK(CLK), .RESETn(RESETn), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_CH(REQ_CH), .REQ_DIV(REQ_DIV), .REQ_EN(REQ_EN), .ACK_VALID(ACK_VALID),
    .ACK_CH(ACK_CH), .ACK_ERR(ACK_ERR), .CLK_EN_OUT(CLK_EN_OUT), .CH_ACTIVE(CH_ACTIVE)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  // A channel started (cnt=0) at edge s with divide d emits its pulse at edges s+k*(d+1).
  task automatic model_edge();
    bit ap_any;
    bit bad;
    bit t;
    int ach;
    ap_any = 0;
    ach = 0;
    cyc++;
    if (!RESETn) begin
      m_busy = 0; m_av = 0; m_ae = 0; m_ach = 0;
      for (int i = 0; i < N; i++) begin
        m_act[i] = 1; m_div[i] = RD; m_s[i] = cyc; m_en[i] = 0;
      end
      return;
    end
    bad = m_busy && (m_pch >= N);
    for (int i = 0; i < N; i++) begin
      t = m_act[i] && ((cyc - m_s[i]) % (m_div[i] + 1) == 0);
      m_en[i] = t;
      if (m_busy && m_pch == i && (t || !m_act[i])) begin
        ap_any = 1; ach = i;
        m_act[i] = m_pen; m_div[i] = m_pdiv; m_s[i] = cyc;
      end
    end
    m_av = ap_any || bad;
    m_ae = bad;
    if (m_av) m_ach = bad ? m_pch : ach;
    if (m_av) m_busy = 0;
    else if (!m_busy && REQ_VALID) begin
      m_busy = 1; m_pch = int'(REQ_CH); m_pdiv = int'(REQ_DIV); m_pen = REQ_EN;
    end
  endtask
  task automatic step();
    logic [N-1:0] e_en, e_act;
    @(posedge CLK);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      e_en[i] = m_en[i];
      e_act[i] = m_act[i];
    end
    chk("req_ready", 32'(REQ_READY), 32'(!m_busy));
    chk("ack_valid", 32'(ACK_VALID), 32'(m_av));
    chk("ack_err", 32'(ACK_ERR), 32'(m_ae));
    if (m_av) chk("ack_ch", 32'(ACK_CH), m_ach);
    chk("clk_en_out", 32'(CLK_EN_OUT), 32'(e_en));
    chk("ch_active", 32'(CH_ACTIVE), 32'(e_act));
  endtask
  task automatic send(input int ch, input int dv, input bit en, input bit wait_ack);
    bit ok;
    REQ_VALID = 1; REQ_CH = HW'(ch); REQ_DIV = CW'(dv); REQ_EN = en;
    ok = 0;
    for (int k = 0; k < 600 && !ok; k++) begin
      ok = !m_busy;
      step();
    end
    REQ_VALID = 0;
    chk("accept_timeout", 32'(ok), 1);
    if (wait_ack) begin
      ok = 0;
      for (int k = 0; k < 600 && !ok; k++) begin
        step();
        ok = m_av;
      end
      chk("ack_timeout", 32'(ok), 1);
    end
  endtask
  initial begin
    int first;
    int n;
    RESETn = 0;
    step(); step();
    RESETn = 1;
    first = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (CLK_EN_OUT[0] && first == 0) first = k;
    end
    chk("first_pulse_edge", 32'(first), 4);
    n = 0;
    while (((cyc - m_s[1]) % (m_div[1] + 1)) != 0 && n < 20) begin step(); n++; end
    step();
    send(1, 7, 1, 1);
    repeat (20) step();
    send(2, 0, 0, 1);
    repeat (6) step();
    send(2, 0, 1, 1);
    repeat (6) step();
    send(5, 9, 1, 1);
    repeat (3) step();
    send(0, 5, 1, 0);
    send(3, 2, 1, 1);
    repeat (10) step();
    send(3, 255, 1, 1);
    send(3, 10, 1, 0);
    repeat (20) step();
    RESETn = 0;
    step();
    RESETn = 1;
    repeat (8) step();
    for (int k = 0; k < 4000; k++) begin
      RESETn = ($urandom_range(0, 599) != 0);
      REQ_VALID = ($urandom_range(0, 3) == 0);
      REQ_CH = HW'($urandom_range(0, 5));
      REQ_DIV = ($urandom_range(0, 9) == 0) ? CW'(255) : CW'($urandom_range(0, 6));
      REQ_EN = ($urandom_range(0, 4) != 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
